// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and default sizing for the decode-stage hazard scoreboard.
package hazard_pkg;

   localparam int NUM_REGS_DEF = 32;
   localparam int MAX_LAT_DEF  = 7;
   localparam int CNT_W_DEF    = 16;
   localparam int REG_AW_DEF   = $clog2(NUM_REGS_DEF);
   localparam int LAT_W_DEF    = $clog2(MAX_LAT_DEF + 1);

   typedef logic [LAT_W_DEF-1:0]  lat_t;
   typedef logic [REG_AW_DEF-1:0] reg_idx_t;

   // x0 is hardwired zero: never tracked, never a hazard source
   localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/hazard_scoreboard_countdown.sv
// Per-register countdown: cycles left until the pending result is forwardable.
module reg_countdown #(
   parameter int LAT_W = 3
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             load,
   input  logic [LAT_W-1:0] load_val,
   output logic [LAT_W-1:0] cnt,
   output logic             nonzero
);

   // A new producer overrides the running count; otherwise count down to zero and hold
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign nonzero = |cnt;

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: RAW/WAW detection against per-register
// countdowns for variable-latency producers, issue stall/fire and stall statistics.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter  int NUM_REGS = NUM_REGS_DEF,
   parameter  int MAX_LAT  = MAX_LAT_DEF,
   parameter  int CNT_W    = CNT_W_DEF,
   localparam int REG_AW   = $clog2(NUM_REGS),
   localparam int LAT_W    = $clog2(MAX_LAT + 1)
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              issue_valid,
   input  logic [REG_AW-1:0] issue_rs1,
   input  logic [REG_AW-1:0] issue_rs2,
   input  logic              issue_use_rs1,
   input  logic              issue_use_rs2,
   input  logic [REG_AW-1:0] issue_rd,
   input  logic              issue_wr,
   input  logic [LAT_W-1:0]  issue_lat,
   input  logic              flush,
   output logic              issue_stall,
   output logic              issue_fire,
   output logic [NUM_REGS-1:0] busy_mask,
   output logic [CNT_W-1:0]  stall_count
);

   localparam logic [LAT_W:0] LAT_BOUND = (LAT_W + 1)'(MAX_LAT);

   logic [LAT_W-1:0] cnt [NUM_REGS];
   logic             raw1;
   logic             raw2;
   logic             waw;
   logic             rd_nonzero;

   assign cnt[0]       = '0;
   assign busy_mask[0] = 1'b0;

   generate
      for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
         reg_countdown #(
            .LAT_W (LAT_W)
         ) u_cnt (
            .clk      (clk),
            .resetn   (resetn),
            .load     (issue_fire & issue_wr & (issue_rd == REG_AW'(r))),
            .load_val (issue_lat),
            .cnt      (cnt[r]),
            .nonzero  (busy_mask[r])
         );
      end
   endgenerate

   // Hazard compare against the counts as they stand this cycle; an instruction's
   // own write is not visible to its reads. WAW keeps writebacks in order.
   always_comb begin
      rd_nonzero = (issue_rd != REG_AW'(REG_ZERO));
      raw1       = issue_use_rs1 & busy_mask[issue_rs1];
      raw2       = issue_use_rs2 & busy_mask[issue_rs2];
      waw        = issue_wr & rd_nonzero & (cnt[issue_rd] > issue_lat);
   end

   // Flush squashes the decode instruction and wins over any stall
   assign issue_stall = issue_valid & ~flush & (raw1 | raw2 | waw);
   assign issue_fire  = issue_valid & ~flush & ~issue_stall;

   // Saturating count of stall cycles
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stall_count <= '0;
      end else if (issue_stall && (stall_count != {CNT_W{1'b1}})) begin
         stall_count <= stall_count + 1'b1;
      end
   end

   a_lat_range: assert property (@(posedge clk) disable iff (!resetn)
      issue_fire |-> ({1'b0, issue_lat} <= LAT_BOUND))
      else $error("issue_lat above MAX_LAT at fire");

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: sequential vector table plus reset and saturation sequences.
module tb_hazard_scoreboard;

   logic        clk = 1'b0;
   logic        resetn;
   logic        issue_valid;
   logic [4:0]  issue_rs1;
   logic [4:0]  issue_rs2;
   logic        issue_use_rs1;
   logic        issue_use_rs2;
   logic [4:0]  issue_rd;
   logic        issue_wr;
   logic [2:0]  issue_lat;
   logic        flush;
   logic        issue_stall;
   logic        issue_fire;
   logic [31:0] busy_mask;
   logic [15:0] stall_count;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        valid;
      logic [4:0]  rs1;
      logic        use1;
      logic [4:0]  rs2;
      logic        use2;
      logic [4:0]  rd;
      logic        wr;
      logic [2:0]  lat;
      logic        fl;
      logic        stall;
      logic        fire;
      logic [31:0] busy;
      logic [15:0] sc;
   } vec_t;

   vec_t tbl[$];

   hazard_scoreboard dut (
      .clk           (clk),
      .resetn        (resetn),
      .issue_valid   (issue_valid),
      .issue_rs1     (issue_rs1),
      .issue_rs2     (issue_rs2),
      .issue_use_rs1 (issue_use_rs1),
      .issue_use_rs2 (issue_use_rs2),
      .issue_rd      (issue_rd),
      .issue_wr      (issue_wr),
      .issue_lat     (issue_lat),
      .flush         (flush),
      .issue_stall   (issue_stall),
      .issue_fire    (issue_fire),
      .busy_mask     (busy_mask),
      .stall_count   (stall_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic addv(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic wr, input logic [2:0] lat, input logic fl,
                       input logic st, input logic fi, input logic [31:0] busy,
                       input logic [15:0] sc);
      vec_t e;
      e.valid = v;  e.rs1 = rs1; e.use1 = u1; e.rs2 = rs2; e.use2 = u2;
      e.rd = rd;    e.wr = wr;   e.lat = lat; e.fl = fl;
      e.stall = st; e.fire = fi; e.busy = busy; e.sc = sc;
      tbl.push_back(e);
   endtask

   task automatic drive(input vec_t e);
      issue_valid   = e.valid;
      issue_rs1     = e.rs1;
      issue_use_rs1 = e.use1;
      issue_rs2     = e.rs2;
      issue_use_rs2 = e.use2;
      issue_rd      = e.rd;
      issue_wr      = e.wr;
      issue_lat     = e.lat;
      flush         = e.fl;
   endtask

   task automatic check_outs(input string tag, input logic st, input logic fi,
                             input logic [31:0] busy, input logic [15:0] sc);
      check({tag, ".stall"}, 32'(issue_stall), 32'(st));
      check({tag, ".fire"},  32'(issue_fire),  32'(fi));
      check({tag, ".busy"},  busy_mask,        busy);
      check({tag, ".scnt"},  32'(stall_count), 32'(sc));
   endtask

   initial begin
      vec_t idle;
      vec_t e;
      idle = '{default: '0};
      //     v  rs1 u1 rs2 u2 rd  wr lat fl  stall fire busy          sc
      addv(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0,     0);   // 0 idle after reset
      addv(1, 5, 1, 6, 1, 0, 0, 0, 0,  0, 1, 32'h0,     0);   // 1 clean issue
      addv(1, 0, 0, 0, 0, 3, 1, 1, 0,  0, 1, 32'h0,     0);   // 2 load x3 lat1
      addv(1, 3, 1, 0, 0, 0, 0, 0, 0,  1, 0, 32'h8,     0);   // 3 load-use bubble
      addv(1, 3, 1, 0, 0, 0, 0, 0, 0,  0, 1, 32'h0,     1);   // 4 fires
      addv(1, 0, 0, 0, 0, 7, 1, 4, 0,  0, 1, 32'h0,     1);   // 5 x7 lat4
      addv(1, 0, 0, 7, 1, 0, 0, 0, 0,  1, 0, 32'h80,    1);   // 6 cnt7=4
      addv(1, 0, 0, 7, 1, 0, 0, 0, 0,  1, 0, 32'h80,    2);   // 7 cnt7=3
      addv(1, 0, 0, 7, 1, 0, 0, 0, 0,  1, 0, 32'h80,    3);   // 8 cnt7=2
      addv(1, 0, 0, 7, 1, 0, 0, 0, 0,  1, 0, 32'h80,    4);   // 9 cnt7=1
      addv(1, 0, 0, 7, 1, 0, 0, 0, 0,  0, 1, 32'h0,     5);   // 10 fires
      addv(1, 0, 0, 0, 0, 9, 1, 5, 0,  0, 1, 32'h0,     5);   // 11 x9 lat5
      addv(1, 0, 0, 0, 0, 9, 1, 1, 0,  1, 0, 32'h200,   5);   // 12 waw cnt9=5
      addv(1, 0, 0, 0, 0, 9, 1, 1, 0,  1, 0, 32'h200,   6);   // 13 cnt9=4
      addv(1, 0, 0, 0, 0, 9, 1, 1, 0,  1, 0, 32'h200,   7);   // 14 cnt9=3
      addv(1, 0, 0, 0, 0, 9, 1, 1, 0,  1, 0, 32'h200,   8);   // 15 cnt9=2
      addv(1, 0, 0, 0, 0, 9, 1, 1, 0,  0, 1, 32'h200,   9);   // 16 cnt9=1 not > lat
      addv(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h200,   9);   // 17 reloaded to 1
      addv(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0,     9);   // 18 drained
      addv(1, 0, 0, 0, 0, 3, 1, 3, 0,  0, 1, 32'h0,     9);   // 19 x3 lat3
      addv(1, 3, 1, 0, 0, 0, 0, 0, 0,  1, 0, 32'h8,     9);   // 20 cnt3=3
      addv(1, 3, 1, 0, 0, 0, 0, 0, 1,  0, 0, 32'h8,    10);   // 21 flush, cnt3=2
      addv(1, 3, 1, 0, 0, 0, 0, 0, 0,  1, 0, 32'h8,    10);   // 22 cnt3=1
      addv(1, 3, 1, 0, 0, 0, 0, 0, 0,  0, 1, 32'h0,    11);   // 23 fires
      addv(1, 0, 0, 0, 0, 4, 1, 5, 1,  0, 0, 32'h0,    11);   // 24 flushed writer
      addv(1, 4, 1, 0, 0, 0, 0, 0, 0,  0, 1, 32'h0,    11);   // 25 x4 untracked
      addv(1, 0, 0, 0, 0, 0, 1, 6, 0,  0, 1, 32'h0,    11);   // 26 write x0
      addv(1, 0, 1, 0, 1, 0, 0, 0, 0,  0, 1, 32'h0,    11);   // 27 read x0
      addv(1, 0, 0, 0, 0,10, 1, 2, 0,  0, 1, 32'h0,    11);   // 28 x10 lat2
      addv(1,11, 1, 0, 0,11, 1, 3, 0,  0, 1, 32'h400,  11);   // 29 rs1==rd
      addv(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'hC00,  11);   // 30
      addv(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h800,  11);   // 31
      addv(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h800,  11);   // 32
      addv(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0,    11);   // 33
      addv(1, 0, 0, 0, 0,13, 1, 0, 0,  0, 1, 32'h0,    11);   // 34 lat0
      addv(1,13, 1, 0, 0, 0, 0, 0, 0,  0, 1, 32'h0,    11);   // 35 no stall

      resetn = 1'b0;
      drive(idle);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_outs("reset", 1'b0, 1'b0, 32'h0, 16'h0);
      @(posedge clk);
      #1 resetn = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         if (i != 0) begin
            @(posedge clk);
            #1;
         end
         drive(tbl[i]);
         @(negedge clk);
         check_outs($sformatf("vec%0d", i), tbl[i].stall, tbl[i].fire, tbl[i].busy, tbl[i].sc);
      end

      // Reset in the middle of a pending countdown
      @(posedge clk);
      #1;
      e = idle; e.valid = 1'b1; e.rd = 5'd12; e.wr = 1'b1; e.lat = 3'd5;
      drive(e);
      @(negedge clk);
      check("mid.fire", 32'(issue_fire), 32'd1);
      @(posedge clk);
      #1;
      e = idle; e.valid = 1'b1; e.rs1 = 5'd12; e.use1 = 1'b1;
      drive(e);
      @(negedge clk);
      check_outs("mid.pending", 1'b1, 1'b0, 32'h1000, 16'd11);
      #1 resetn = 1'b0;
      #1;
      check_outs("mid.reset", 1'b0, 1'b1, 32'h0, 16'd0);
      @(posedge clk);
      #1 resetn = 1'b1;

      // Self-dependent writer: 7 stalls then a fire that reloads 7, repeated
      e = idle; e.valid = 1'b1; e.rs1 = 5'd8; e.use1 = 1'b1;
      e.rd = 5'd8; e.wr = 1'b1; e.lat = 3'd7;
      drive(e);
      repeat (81) @(posedge clk);
      @(negedge clk);
      check("sat.early", 32'(stall_count), 32'd70);
      repeat (75000) @(posedge clk);
      @(negedge clk);
      check("sat.max", 32'(stall_count), 32'd65535);
      repeat (16) @(posedge clk);
      @(negedge clk);
      check("sat.hold", 32'(stall_count), 32'd65535);

      drive(idle);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
